conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
//   K=7, rate-1/2 convolutional encoder (g0 = 133, g1 = 171 octal) with
//   optional 802.11a puncturing to rate 2/3 or 3/4, serial in / serial out
//   with valid/ready handshakes on both sides.
//
//   Optional feature macro: CONV_ENC_PUNCTURE_EN
//     defined   : rate input is latched on each accepted in_sof bit and the
//                 coded stream is punctured (00 = 1/2, 01 = 2/3, 10 = 3/4,
//                 11 behaves as 00).
//     undefined : rate is ignored; every accepted bit emits A then B.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   in_valid   in   in_bit carries a scrambled data bit
//   in_bit     in   data bit
//   in_sof     in   in_bit is the first bit of a frame
//   in_ready   out  encoder accepts in_bit this cycle
//   rate       in   puncture select (used only with CONV_ENC_PUNCTURE_EN)
//   out_valid  out  out_bit carries a coded bit
//   out_bit    out  coded, punctured serial bit
//   out_ready  in   downstream accepts out_bit this cycle
// ---------------------------------------------------------------------------
module conv_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_sof,
  output logic       in_ready,
  input  logic [1:0] rate,
  output logic       out_valid,
  output logic       out_bit,
  input  logic       out_ready
);

  // hist[0] is the bit accepted one transfer ago (d1), hist[5] is d6.
  logic [5:0] hist;
  logic [5:0] hist_eff;
  logic       enc_a;
  logic       enc_b;
  logic       accept;
  logic       pop;
  logic       emit_a;
  logic       emit_b;

  // Output buffer: entry 0 is the registered out_bit/out_valid pair itself,
  // entry 1 (buf1/vld1) is the bit queued behind it.
  logic       vld1;
  logic       buf1;

  assign pop = out_valid & out_ready;

  // Accept only when the buffer will be empty at the clock edge: either it
  // is empty now, or its single bit leaves this cycle. This guarantees both
  // coded bits of an input always fit.
  assign in_ready = ~out_valid | (~vld1 & out_ready);
  assign accept   = in_valid & in_ready;

  // A frame start encodes against an all-zero history.
  assign hist_eff = in_sof ? 6'd0 : hist;

  assign enc_a = in_bit ^ hist_eff[1] ^ hist_eff[2] ^ hist_eff[4] ^ hist_eff[5];
  assign enc_b = in_bit ^ hist_eff[0] ^ hist_eff[1] ^ hist_eff[2] ^ hist_eff[5];

`ifdef CONV_ENC_PUNCTURE_EN
  logic [1:0] rate_reg;
  logic [1:0] rate_eff;
  logic [1:0] phase_reg;
  logic [1:0] phase_eff;
  logic [1:0] phase_next;

  // A frame start takes the rate from the port (reserved 11 folds to 1/2)
  // and restarts the puncture pattern; otherwise the latched values rule.
  assign rate_eff  = in_sof ? ((rate == 2'b11) ? 2'b00 : rate) : rate_reg;
  assign phase_eff = in_sof ? 2'd0 : phase_reg;

  always_comb begin
    emit_a     = 1'b1;
    emit_b     = 1'b1;
    phase_next = 2'd0;
    case (rate_eff)
      2'b01: begin
        // 2/3: phase0 A,B ; phase1 A
        emit_b     = (phase_eff == 2'd0);
        phase_next = (phase_eff == 2'd1) ? 2'd0 : phase_eff + 2'd1;
      end
      2'b10: begin
        // 3/4: phase0 A,B ; phase1 A ; phase2 B
        emit_a     = (phase_eff != 2'd2);
        emit_b     = (phase_eff != 2'd1);
        phase_next = (phase_eff == 2'd2) ? 2'd0 : phase_eff + 2'd1;
      end
      default: begin
        emit_a     = 1'b1;
        emit_b     = 1'b1;
        phase_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_reg  <= 2'b00;
      phase_reg <= 2'd0;
    end else if (accept) begin
      rate_reg  <= rate_eff;
      phase_reg <= phase_next;
    end
  end
`else
  // Rate is not used in the unpunctured build.
  logic unused_rate;
  assign unused_rate = ^rate;
  assign emit_a      = 1'b1;
  assign emit_b      = 1'b1;
`endif

  // Encoder history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 6'd0;
    end else if (accept) begin
      hist <= {hist_eff[4:0], in_bit};
    end
  end

  // Output buffer. On accept the buffer is (or is becoming) empty, so the
  // emitted bits load straight into it: the first emitted bit (A if kept,
  // else B) goes to the output register, B is queued behind only when both
  // are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      vld1      <= 1'b0;
      buf1      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= emit_a ? enc_a : enc_b;
      vld1      <= emit_a & emit_b;
      buf1      <= enc_b;
    end else if (pop) begin
      out_valid <= vld1;
      out_bit   <= buf1;
      vld1      <= 1'b0;
    end
  end

endmodule
